// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrseq.sv
// Power-switch sequencer for a switched power domain.
// The block ramps NSEG row segments on, one every STEP_CYC clocks, and ramps
// them off in reverse order. SW_EN is always thermometer-coded from bit 0.
// Optional feature macro: GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_ISO_EN adds the
// ISO_EN isolation output. ISO_EN is low only while the domain is fully on.
module gf180mcu_fd_sc_mcu7t5v0__pwrseq #(
  parameter int NSEG     = 4,
  parameter int STEP_CYC = 8
) (
  input  logic            CLK,
  input  logic            RST,
  inout  wire             VDD,
  inout  wire             VSS,
  input  logic            PWR_REQ,
  output logic            PWR_ACK,
  output logic [NSEG-1:0] SW_EN
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_ISO_EN
  ,
  output logic            ISO_EN
`endif
);

  localparam int CNT_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NSEG-1:0]   sw_q, sw_d;
  logic              ack_q, ack_d;

  // Supply pins carry no logic; fold them into a sink so they are referenced.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // Turn on the next segment above the ones already on.
  function automatic logic [NSEG-1:0] sw_grow(input logic [NSEG-1:0] v);
    return (v << 1) | NSEG'(1);
  endfunction

  // Turn off the highest segment that is on.
  function automatic logic [NSEG-1:0] sw_shrink(input logic [NSEG-1:0] v);
    return v >> 1;
  endfunction

  // Next-state logic: sequencing, abort handling and step timing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    case (state_q)
      S_OFF: begin
        if (PWR_REQ) begin
          state_d = S_UP;
          cnt_d   = '0;
          sw_d    = sw_grow(sw_q);
        end
      end
      S_UP: begin
        if (!PWR_REQ) begin
          state_d = S_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (&sw_q) state_d = S_ON;
          else       sw_d    = sw_grow(sw_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ON: begin
        if (!PWR_REQ) begin
          state_d = S_DOWN;
          cnt_d   = '0;
        end
      end
      S_DOWN: begin
        if (PWR_REQ) begin
          state_d = S_UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sw_d  = sw_shrink(sw_q);
          // Dropping the last segment completes the power-down.
          if (sw_q == NSEG'(1)) state_d = S_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
        sw_d    = '0;
      end
    endcase
    ack_d = (state_d == S_ON);
  end

  // State, counter and output registers; reset drops every segment at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      sw_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      ack_q   <= ack_d;
    end
  end

  assign PWR_ACK = ack_q;
  assign SW_EN   = sw_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_ISO_EN
  logic iso_q;

  // Isolation is released exactly while the domain is acknowledged on.
  always_ff @(posedge CLK) begin
    if (RST) iso_q <= 1'b1;
    else     iso_q <= ~ack_d;
  end

  assign ISO_EN = iso_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__pwrseq.sv
// Bench for the power-switch sequencer: directed timing scenarios followed by
// randomized request/reset traffic, all checked against a segment-count model.
// Two instances: NSEG=4/STEP_CYC=8 and NSEG=1/STEP_CYC=1.
module tb_gf180mcu_fd_sc_mcu7t5v0__pwrseq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       ack0, ack1;
  logic [3:0] sw0;
  logic [0:0] sw1;
  wire        vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_ISO_EN
  logic       iso0, iso1;
`endif

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__pwrseq #(.NSEG(4), .STEP_CYC(8)) u_dut0 (
    .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .PWR_REQ(req),
    .PWR_ACK(ack0), .SW_EN(sw0)
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_ISO_EN
    , .ISO_EN(iso0)
`endif
  );

  gf180mcu_fd_sc_mcu7t5v0__pwrseq #(.NSEG(1), .STEP_CYC(1)) u_dut1 (
    .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .PWR_REQ(req),
    .PWR_ACK(ack1), .SW_EN(sw1)
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_ISO_EN
    , .ISO_EN(iso1)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: number of segments on, ramp direction, time in step.
  int m_n[2]   = '{4, 1};
  int m_s[2]   = '{8, 1};
  int m_lvl[2] = '{0, 0};
  int m_t[2]   = '{0, 0};
  int m_dir[2] = '{0, 0};   // +1 ramping up, -1 ramping down, 0 settled
  bit m_ack[2] = '{0, 0};
  logic [3:0] prev0 = '0;
  logic       prev1 = 1'b0;

  task automatic model_edge(input int i, input bit r, input bit rs);
    if (rs) begin
      m_lvl[i] = 0; m_t[i] = 0; m_dir[i] = 0; m_ack[i] = 0;
    end else if (m_ack[i]) begin
      if (!r) begin m_ack[i] = 0; m_dir[i] = -1; m_t[i] = 0; end
    end else if (m_dir[i] == 0) begin
      if (r) begin m_lvl[i] = 1; m_dir[i] = 1; m_t[i] = 0; end
    end else if (m_dir[i] == 1) begin
      if (!r) begin
        m_dir[i] = -1; m_t[i] = 0;
      end else if (m_t[i] == m_s[i] - 1) begin
        m_t[i] = 0;
        if (m_lvl[i] < m_n[i]) m_lvl[i]++;
        else begin m_ack[i] = 1; m_dir[i] = 0; end
      end else m_t[i]++;
    end else begin
      if (r) begin
        m_dir[i] = 1; m_t[i] = 0;
      end else if (m_t[i] == m_s[i] - 1) begin
        m_t[i] = 0;
        m_lvl[i]--;
        if (m_lvl[i] == 0) m_dir[i] = 0;
      end else m_t[i]++;
    end
  endtask

  // One clock edge: advance the model with the sampled inputs, then compare.
  task automatic step();
    bit rs;
    @(posedge clk);
    rs = rst;
    model_edge(0, req, rst);
    model_edge(1, req, rst);
    #1;
    chk("sw0", {28'b0, sw0}, (32'd1 << m_lvl[0]) - 1);
    chk("ack0", {31'b0, ack0}, {31'b0, m_ack[0]});
    chk("sw1", {31'b0, sw1}, (32'd1 << m_lvl[1]) - 1);
    chk("ack1", {31'b0, ack1}, {31'b0, m_ack[1]});
    chk("thermo0", {28'b0, sw0 & (sw0 + 4'd1)}, 32'd0);
    if (!rs) chk("onechg0", {31'b0, $countones(sw0 ^ prev0) <= 1}, 32'd1);
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_ISO_EN
    chk("iso0", {31'b0, iso0}, {31'b0, !m_ack[0]});
    chk("iso1", {31'b0, iso1}, {31'b0, !m_ack[1]});
`endif
    prev0 = sw0;
    prev1 = sw1[0];
  endtask

  initial begin
    // Reset state
    rst = 1'b1; req = 1'b1;
    step(); step();
    chk("rst_sw0", {28'b0, sw0}, 32'd0);
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    rst = 1'b0; req = 1'b0;
    step(); step();

    // Power-up ramp; req changes just after edge E0
    req = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      step();
      if (i == 1)  chk("up_b0", {28'b0, sw0}, 32'h1);
      if (i == 8)  chk("up_hold", {28'b0, sw0}, 32'h1);
      if (i == 9)  chk("up_b1", {28'b0, sw0}, 32'h3);
      if (i == 17) chk("up_b2", {28'b0, sw0}, 32'h7);
      if (i == 25) chk("up_b3", {28'b0, sw0}, 32'hf);
      if (i == 32) chk("ack_early", {31'b0, ack0}, 32'd0);
      if (i == 33) chk("ack_up", {31'b0, ack0}, 32'd1);
      if (i == 1)  chk("s1_up_sw", {31'b0, sw1}, 32'd1);
      if (i == 1)  chk("s1_up_ack", {31'b0, ack1}, 32'd0);
      if (i == 2)  chk("s1_ack", {31'b0, ack1}, 32'd1);
    end

    // Power-down ramp from ON
    req = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      step();
      if (i == 1)  chk("dn_ack", {31'b0, ack0}, 32'd0);
      if (i == 8)  chk("dn_hold", {28'b0, sw0}, 32'hf);
      if (i == 9)  chk("dn_b3", {28'b0, sw0}, 32'h7);
      if (i == 17) chk("dn_b2", {28'b0, sw0}, 32'h3);
      if (i == 25) chk("dn_b1", {28'b0, sw0}, 32'h1);
      if (i == 33) chk("dn_b0", {28'b0, sw0}, 32'h0);
      if (i == 1)  chk("s1_dn_ack", {31'b0, ack1}, 32'd0);
      if (i == 1)  chk("s1_dn_sw", {31'b0, sw1}, 32'd1);
      if (i == 2)  chk("s1_dn_off", {31'b0, sw1}, 32'd0);
    end

    // Abort during power-up with two segments on
    req = 1'b1;
    for (int i = 1; i <= 9; i++) step();
    chk("ab_start", {28'b0, sw0}, 32'h3);
    req = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i == 8)  chk("ab_hold", {28'b0, sw0}, 32'h3);
      if (i == 9)  chk("ab_b1", {28'b0, sw0}, 32'h1);
      if (i == 16) chk("ab_hold2", {28'b0, sw0}, 32'h1);
      if (i == 17) chk("ab_b0", {28'b0, sw0}, 32'h0);
      chk("ab_ack", {31'b0, ack0}, 32'd0);
    end

    // Reset while ON, request held high
    req = 1'b1;
    for (int i = 1; i <= 34; i++) step();
    chk("on_before_rst", {31'b0, ack0}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_on_sw", {28'b0, sw0}, 32'd0);
    chk("rst_on_ack", {31'b0, ack0}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      step();
      if (i == 1)  chk("re_b0", {28'b0, sw0}, 32'h1);
      if (i == 25) chk("re_b3", {28'b0, sw0}, 32'hf);
      if (i == 33) chk("re_ack", {31'b0, ack0}, 32'd1);
    end

    // Randomized request toggles with occasional reset pulses
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 2) == 0) req = ~req;
      end else if ($urandom_range(0, 29) == 0) begin
        req = ~req;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
